blue_die_roll_ctrl: RTL and testbench

//  Sequences the blue-die sprite: runs a roll animation (face changes that slow down frame by frame)
//  and settles on a pseudo-random face. Renders the die on the VGA scan.

---
 rtl/blue_die_roll_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_blue_die_roll_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/blue_die_roll_ctrl.sv
// Blue-die sprite sequencer: LFSR-driven roll animation plus a 3-cycle pixel pipe (addr -> ROM -> palette -> RGB).
// Optional macro DIE_FRAME_EN draws a yellow 1-px ring around the idle die once a roll has completed.
module blue_die_roll_ctrl #(
  parameter logic [9:0]  DIE_X      = 10'd288,
  parameter logic [9:0]  DIE_Y      = 10'd208,
  parameter int          SPR_W      = 32,
  parameter int          SPR_H      = 32,
  parameter int          MIN_PERIOD = 2,
  parameter int          MAX_PERIOD = 16,
  parameter int          SPIN_STEPS = 12,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        roll_req,
  output logic        roll_busy,
  output logic        roll_done,
  output logic [2:0]  face,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [12:0] rom_addr,
  input  logic [3:0]  rom_index,
  output logic [3:0]  pal_index,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        die_hit
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SPIN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam logic [10:0] X_LO = 11'(DIE_X);
  localparam logic [10:0] X_HI = 11'(int'(DIE_X) + SPR_W);
  localparam logic [10:0] Y_LO = 11'(DIE_Y);
  localparam logic [10:0] Y_HI = 11'(int'(DIE_Y) + SPR_H);

  logic [1:0] state_q, state_d;
  logic [2:0] face_q, face_d;
  logic [7:0] step_q, step_d;
  logic [7:0] period_q, period_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] lfsr_q;
  logic [2:0] f_rand, face_next;
  logic [7:0] period_inc;

  // Random pick is rejected when out of 1..6 or a repeat, so every change is visible.
  assign f_rand     = lfsr_q[2:0];
  assign face_next  = (f_rand != 3'd0 && f_rand <= 3'd6 && f_rand != face_q) ? f_rand :
                      (face_q == 3'd6) ? 3'd1 : face_q + 3'd1;
  assign period_inc = (period_q >= 8'(MAX_PERIOD)) ? 8'(MAX_PERIOD) : period_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    face_d   = face_q;
    step_d   = step_q;
    period_d = period_q;
    fcnt_d   = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (roll_req) begin
          state_d  = S_SPIN;
          step_d   = 8'd0;
          period_d = 8'(MIN_PERIOD);
          fcnt_d   = 8'(MIN_PERIOD);
        end
      end
      S_SPIN: begin
        if (frame_tick) begin
          if (fcnt_q == 8'd1) begin
            face_d   = face_next;
            step_d   = step_q + 8'd1;
            period_d = period_inc;
            fcnt_d   = period_inc;
            if (step_q + 8'd1 == 8'(SPIN_STEPS)) state_d = S_DONE;
          end else begin
            fcnt_d = fcnt_q - 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      face_q   <= 3'd1;
      step_q   <= 8'd0;
      period_q <= 8'(MIN_PERIOD);
      fcnt_q   <= 8'(MIN_PERIOD);
      lfsr_q   <= 8'hA5;
    end else begin
      state_q  <= state_d;
      face_q   <= face_d;
      step_q   <= step_d;
      period_q <= period_d;
      fcnt_q   <= fcnt_d;
      lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign roll_busy = (state_q == S_SPIN);
  assign roll_done = (state_q == S_DONE);
  assign face      = face_q;

  logic          in_box;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic [12:0]   addr_d;
  logic [12:0]   rom_addr_q;
  logic          in_box1_q, blank1_q, in_box2_q, blank2_q;
  logic          ring2;
  logic [11:0]   rgb_d, rgb_q;
  logic          hit_d, hit_q;

  assign in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                  ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
  assign x_off  = XW'(DrawX - DIE_X);
  assign y_off  = YW'(DrawY - DIE_Y);
  // Power-of-2 width makes y*SPR_W + x a plain concatenation.
  assign addr_d = (13'(face_q - 3'd1) << (XW + YW)) + 13'({y_off, x_off});

`ifdef DIE_FRAME_EN
  logic shown_q, ring_geom, ring1_q, ring2_q;
  always_ff @(posedge vga_clk) begin
    if (!reset_n)                                shown_q <= 1'b0;
    else if (state_q == S_DONE)                  shown_q <= 1'b1;
    else if (state_q == S_IDLE && roll_req)      shown_q <= 1'b0;
  end
  assign ring_geom = !in_box &&
    ((({1'b0, DrawX} == X_LO - 11'd1 || {1'b0, DrawX} == X_HI) &&
      {1'b0, DrawY} >= Y_LO - 11'd1 && {1'b0, DrawY} <= Y_HI) ||
     (({1'b0, DrawY} == Y_LO - 11'd1 || {1'b0, DrawY} == Y_HI) &&
      {1'b0, DrawX} >= X_LO - 11'd1 && {1'b0, DrawX} <= X_HI));
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      ring1_q <= 1'b0;
      ring2_q <= 1'b0;
    end else begin
      ring1_q <= ring_geom && shown_q && (state_q == S_IDLE);
      ring2_q <= ring1_q;
    end
  end
  assign ring2 = ring2_q;
`else
  assign ring2 = 1'b0;
`endif

  always_comb begin
    rgb_d = BG_RGB;
    hit_d = 1'b0;
    if (!blank2_q) begin
      rgb_d = 12'h000;
    end else if (in_box2_q && rom_index != 4'd0) begin
      rgb_d = pal_rgb;
      hit_d = 1'b1;
    end else if (ring2) begin
      rgb_d = 12'hFF0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_addr_q <= 13'd0;
      in_box1_q  <= 1'b0;
      blank1_q   <= 1'b0;
      in_box2_q  <= 1'b0;
      blank2_q   <= 1'b0;
      rgb_q      <= 12'h000;
      hit_q      <= 1'b0;
    end else begin
      if (in_box) rom_addr_q <= addr_d;
      in_box1_q <= in_box;
      blank1_q  <= blank;
      in_box2_q <= in_box1_q;
      blank2_q  <= blank1_q;
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pal_index = rom_index;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign die_hit   = hit_q;

endmodule

// File: tb/tb_blue_die_roll_ctrl.sv
// Scoreboard bench for blue_die_roll_ctrl: face sequence against an LFSR model, pixel pipe against a ROM/palette model.
`timescale 1ns/1ps
module tb_blue_die_roll_ctrl;
  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        roll_req = 1'b0;
  logic        blank = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [3:0]  rom_index = 4'd0;
  logic [11:0] pal_rgb;
  logic        roll_busy, roll_done, die_hit;
  logic [2:0]  face;
  logic [12:0] rom_addr;
  logic [3:0]  pal_index, red, green, blue;

  int n_pass = 0;
  int n_total = 0;

  blue_die_roll_ctrl dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick), .roll_req(roll_req),
    .roll_busy(roll_busy), .roll_done(roll_done), .face(face),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .rom_addr(rom_addr), .rom_index(rom_index), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .red(red), .green(green), .blue(blue), .die_hit(die_hit)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_fn(input logic [12:0] a);
    logic [12:0] t;
    if (a == 13'd35 || a == 13'd3107) return 4'd5;
    t = a * 13'd3 + 13'd1;
    return t[3:0];
  endfunction

  function automatic logic [11:0] pal_fn(input logic [3:0] i);
    if (i == 4'd5) return 12'h887;
    return {i, ~i, i};
  endfunction

  always @(posedge vga_clk) rom_index <= rom_fn(rom_addr);
  assign pal_rgb = pal_fn(pal_index);

  logic [7:0] m_lfsr;
  always @(posedge vga_clk) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int next_face(input int cur, input logic [7:0] l);
    int f;
    f = int'(l[2:0]);
    if (f >= 1 && f <= 6 && f != cur) return f;
    return (cur == 6) ? 1 : cur + 1;
  endfunction

  typedef struct packed { logic [11:0] rgb; logic hit; } pix_t;
  pix_t        pix_sb[$];
  logic [12:0] addr_sb[$];
  int          face_sb[$];

  int          m_face = 1;
  bit          m_shown = 0;
  logic [12:0] m_addr = 13'd0;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    m_face = 1; m_shown = 0; m_addr = 13'd0;
    n_total++; if (face !== 3'd1) $display("FAIL reset_face got=%0d exp=1", face); else n_pass++;
    n_total++; if (roll_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", roll_busy); else n_pass++;
    n_total++; if (roll_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", roll_done); else n_pass++;
    n_total++; if (rom_addr !== 13'd0) $display("FAIL reset_addr got=%0d exp=0", rom_addr); else n_pass++;
    n_total++; if ({red, green, blue, die_hit} !== 13'd0)
      $display("FAIL reset_rgb got=%h/%b exp=000/0", {red, green, blue}, die_hit); else n_pass++;
  endtask

  task automatic test_pixels(input string tag);
    int   xs[8] = '{291, 293, 320, 291, 319, 287, 300, 288};
    int   ys[8] = '{209, 208, 209, 209, 239, 207, 250, 208};
    bit   bs[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    bit   inb, ring;
    pix_t e, got;
    logic [12:0] ea;
    for (int k = 0; k < 11; k++) begin
      @(negedge vga_clk);
      if (k >= 1 && k <= 8) begin
        ea = addr_sb.pop_front();
        n_total++; if (rom_addr !== ea)
          $display("FAIL %s_addr[%0d] got=%0d exp=%0d", tag, k - 1, rom_addr, ea); else n_pass++;
      end
      if (k >= 3) begin
        e = pix_sb.pop_front();
        got.rgb = {red, green, blue};
        got.hit = die_hit;
        n_total++; if (got.rgb !== e.rgb)
          $display("FAIL %s_rgb[%0d] got=%h exp=%h", tag, k - 3, got.rgb, e.rgb); else n_pass++;
        n_total++; if (got.hit !== e.hit)
          $display("FAIL %s_hit[%0d] got=%b exp=%b", tag, k - 3, got.hit, e.hit); else n_pass++;
      end
      if (k < 8) begin
        DrawX = 10'(xs[k]); DrawY = 10'(ys[k]); blank = bs[k];
        inb  = xs[k] >= 288 && xs[k] < 320 && ys[k] >= 208 && ys[k] < 240;
        ring = !inb && (((xs[k] == 287 || xs[k] == 320) && ys[k] >= 207 && ys[k] <= 240) ||
                        ((ys[k] == 207 || ys[k] == 240) && xs[k] >= 287 && xs[k] <= 320));
        if (inb) m_addr = 13'((m_face - 1) * 1024 + (ys[k] - 208) * 32 + (xs[k] - 288));
        addr_sb.push_back(m_addr);
        e.rgb = 12'h000; e.hit = 1'b0;
        if (bs[k]) begin
          if (inb && rom_fn(m_addr) != 4'd0) begin
            e.rgb = pal_fn(rom_fn(m_addr)); e.hit = 1'b1;
          end
`ifdef DIE_FRAME_EN
          else if (ring && m_shown) e.rgb = 12'hFF0;
`endif
        end
        pix_sb.push_back(e);
      end else begin
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
      end
    end
  endtask

  task automatic test_roll(input string tag, input bit tick_on_accept);
    int ticks = 0, next_chg = 2, per = 2, changes = 0, spurious = 0, prev, exp_f;
    bit chg;
    @(negedge vga_clk);
    roll_req = 1'b1; frame_tick = tick_on_accept;
    @(negedge vga_clk);
    roll_req = 1'b0; frame_tick = 1'b0; m_shown = 0;
    n_total++; if (roll_busy !== 1'b1) $display("FAIL %s_accept_busy got=%b exp=1", tag, roll_busy); else n_pass++;
    while (changes < 12 && ticks < 200) begin
      for (int c = 0; c < 99; c++) begin
        @(negedge vga_clk);
        if (roll_done) spurious++;
        roll_req = (ticks == 30 && c > 40 && c < 60);
      end
      @(negedge vga_clk);
      frame_tick = 1'b1; ticks++; prev = m_face; chg = (ticks == next_chg);
      if (chg) begin
        exp_f = next_face(m_face, m_lfsr);
        changes++; per = (per + 1 > 16) ? 16 : per + 1; next_chg += per;
      end else exp_f = m_face;
      face_sb.push_back(exp_f);
      m_face = exp_f;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      exp_f = face_sb.pop_front();
      n_total++; if (int'(face) !== exp_f)
        $display("FAIL %s_face_tick%0d got=%0d exp=%0d", tag, ticks, face, exp_f); else n_pass++;
      if (chg) begin
        n_total++; if (int'(face) == prev)
          $display("FAIL %s_face_differs_tick%0d got=%0d prev=%0d", tag, ticks, face, prev); else n_pass++;
      end
      if (changes < 12) begin
        n_total++; if ({roll_busy, roll_done} !== 2'b10)
          $display("FAIL %s_busy_tick%0d got=%b%b exp=10", tag, ticks, roll_busy, roll_done); else n_pass++;
      end else begin
        n_total++; if ({roll_busy, roll_done} !== 2'b01)
          $display("FAIL %s_done_pulse got=%b%b exp=01", tag, roll_busy, roll_done); else n_pass++;
      end
    end
    @(negedge vga_clk);
    m_shown = 1;
    n_total++; if (roll_done !== 1'b0) $display("FAIL %s_done_width got=%b exp=0", tag, roll_done); else n_pass++;
    n_total++; if (spurious != 0) $display("FAIL %s_spurious_done got=%0d exp=0", tag, spurious); else n_pass++;
    n_total++; if (ticks != 90) $display("FAIL %s_tick_count got=%0d exp=90", tag, ticks); else n_pass++;
  endtask

  task automatic test_reset_midroll();
    int ticks = 0, dones = 0;
    @(negedge vga_clk);
    roll_req = 1'b1;
    @(negedge vga_clk);
    roll_req = 1'b0;
    while (ticks < 20) begin
      repeat (9) @(negedge vga_clk);
      frame_tick = 1'b1; ticks++;
      @(negedge vga_clk);
      frame_tick = 1'b0;
    end
    n_total++; if (roll_busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", roll_busy); else n_pass++;
    reset_n = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    m_face = 1; m_shown = 0; m_addr = 13'd0;
    n_total++; if (face !== 3'd1) $display("FAIL mid_face got=%0d exp=1", face); else n_pass++;
    n_total++; if (roll_busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", roll_busy); else n_pass++;
    n_total++; if (rom_addr !== 13'd0) $display("FAIL mid_addr got=%0d exp=0", rom_addr); else n_pass++;
    if (roll_done) dones++;
    repeat (5) begin
      @(negedge vga_clk);
      if (roll_done) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL mid_no_done got=%0d exp=0", dones); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pixels("pix_face1");
    test_roll("roll", 1'b0);
    test_pixels("pix_after_roll");
    test_roll("roll_tick_accept", 1'b1);
    test_pixels("pix_back_to_back");
    test_reset_midroll();
    test_pixels("pix_after_reset");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
